jtag_tap_ctrl: RTL

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_pkg.sv | 55 +++++
 rtl/jtag_tap_fsm.sv | 19 +
 rtl/jtag_tap_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, instruction codes and the IEEE 1149.1
// next-state function used by both the FSM and the IR update logic.
package jtag_pkg;

   typedef enum logic [3:0] {
      StTestLogicReset = 4'd0,
      StRunTestIdle    = 4'd1,
      StSelectDr       = 4'd2,
      StCaptureDr      = 4'd3,
      StShiftDr        = 4'd4,
      StExit1Dr        = 4'd5,
      StPauseDr        = 4'd6,
      StExit2Dr        = 4'd7,
      StUpdateDr       = 4'd8,
      StSelectIr       = 4'd9,
      StCaptureIr      = 4'd10,
      StShiftIr        = 4'd11,
      StExit1Ir        = 4'd12,
      StPauseIr        = 4'd13,
      StExit2Ir        = 4'd14,
      StUpdateIr       = 4'd15
   } tap_state_e;

   localparam logic [1:0] IrBypass0  = 2'b00;
   localparam logic [1:0] IrUserLed  = 2'b01;
   localparam logic [1:0] IrIdcode   = 2'b10;
   localparam logic [1:0] IrBypass1  = 2'b11;
   localparam logic [1:0] IrCaptured = 2'b01;

   function automatic tap_state_e tap_next(input tap_state_e st, input logic tms);
      tap_state_e nxt;
      nxt = StTestLogicReset;
      case (st)
         StTestLogicReset: nxt = tms ? StTestLogicReset : StRunTestIdle;
         StRunTestIdle:    nxt = tms ? StSelectDr       : StRunTestIdle;
         StSelectDr:       nxt = tms ? StSelectIr       : StCaptureDr;
         StCaptureDr:      nxt = tms ? StExit1Dr        : StShiftDr;
         StShiftDr:        nxt = tms ? StExit1Dr        : StShiftDr;
         StExit1Dr:        nxt = tms ? StUpdateDr       : StPauseDr;
         StPauseDr:        nxt = tms ? StExit2Dr        : StPauseDr;
         StExit2Dr:        nxt = tms ? StUpdateDr       : StShiftDr;
         StUpdateDr:       nxt = tms ? StSelectDr       : StRunTestIdle;
         StSelectIr:       nxt = tms ? StTestLogicReset : StCaptureIr;
         StCaptureIr:      nxt = tms ? StExit1Ir        : StShiftIr;
         StShiftIr:        nxt = tms ? StExit1Ir        : StShiftIr;
         StExit1Ir:        nxt = tms ? StUpdateIr       : StPauseIr;
         StPauseIr:        nxt = tms ? StExit2Ir        : StPauseIr;
         StExit2Ir:        nxt = tms ? StUpdateIr       : StShiftIr;
         StUpdateIr:       nxt = tms ? StSelectDr       : StRunTestIdle;
         default:          nxt = StTestLogicReset;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register; next state follows the standard tms table.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       tck,
   input  logic       aclr_n,
   input  logic       tms,
   output tap_state_e state
);

   always_ff @(posedge tck or negedge aclr_n) begin
      if (!aclr_n) begin
         state <= StTestLogicReset;
      end else begin
         state <= tap_next(state, tms);
      end
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP with 2-bit IR, IDCODE and BYPASS data registers, and strobes for a
// downstream USER_LED data register.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   // Bit 0 must be 1 so the IDCODE is distinguishable from BYPASS on the chain.
   parameter logic [31:0] IDCODE = 32'h1000_0A3B
) (
   input  logic tck,
   input  logic aclr_n,
   input  logic tms,
   input  logic tdi,
   input  logic dr_tdo,
   output logic tdo,
   output logic ir_in,
   output logic v_sdr,
   output logic v_cdr,
   output logic udr,
   output logic dr_aclr
);

   tap_state_e  state;
   tap_state_e  state_next;
   logic [1:0]  ir_q;
   logic [1:0]  ir_shift_q;
   logic [31:0] id_shift_q;
   logic        bypass_q;
   logic        sel_user;
   logic        sel_id;
   logic        sel_bypass;

   jtag_tap_fsm u_fsm (
      .tck    (tck),
      .aclr_n (aclr_n),
      .tms    (tms),
      .state  (state)
   );

   always_comb begin
      state_next = tap_next(state, tms);
      sel_user   = (ir_q == IrUserLed);
      sel_id     = (ir_q == IrIdcode);
      sel_bypass = !sel_user && !sel_id;
   end

   // Active IR changes only when leaving UPDATE_IR, or on the edge entering reset.
   always_ff @(posedge tck or negedge aclr_n) begin
      if (!aclr_n) begin
         ir_q       <= IrIdcode;
         ir_shift_q <= IrCaptured;
      end else begin
         if (state_next == StTestLogicReset) begin
            ir_q <= IrIdcode;
         end else if (state == StUpdateIr) begin
            ir_q <= ir_shift_q;
         end
         if (state == StCaptureIr) begin
            ir_shift_q <= IrCaptured;
         end else if (state == StShiftIr) begin
            ir_shift_q <= {tdi, ir_shift_q[1]};
         end
      end
   end

   always_ff @(posedge tck or negedge aclr_n) begin
      if (!aclr_n) begin
         id_shift_q <= IDCODE;
         bypass_q   <= 1'b0;
      end else if (state == StCaptureDr) begin
         if (sel_id)     id_shift_q <= IDCODE;
         if (sel_bypass) bypass_q   <= 1'b0;
      end else if (state == StShiftDr) begin
         if (sel_id)     id_shift_q <= {tdi, id_shift_q[31:1]};
         if (sel_bypass) bypass_q   <= tdi;
      end
   end

   // Strobes depend only on registered state and IR, never on tms.
   always_comb begin
      ir_in   = sel_user;
      v_sdr   = sel_user && (state == StShiftDr);
      v_cdr   = sel_user && (state == StCaptureDr);
      udr     = sel_user && (state == StUpdateDr);
      dr_aclr = (state == StTestLogicReset);
      tdo     = 1'b0;
      if (state == StShiftIr) begin
         tdo = ir_shift_q[0];
      end else if (state == StShiftDr) begin
         if (sel_user)    tdo = dr_tdo;
         else if (sel_id) tdo = id_shift_q[0];
         else             tdo = bypass_q;
      end
   end

endmodule
